soc_uart_rx: RTL and testbench
==============================

# soc_uart_rx

UART receiver for the processor-less SoC. It sits directly downstream of the `cio_rx_i` pad input and upstream of the UART register/command logic. It synchronises the raw RX line, oversamples it 16x with majority voting, and frames 8N1 characters. Received bytes are buffered in a small FIFO and offered on a valid/ready interface, with one-cycle pulses for framing and overrun errors.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of two, ≥2.
- `SYNC_STAGES`, default 2: flops in the RX input synchroniser, ≥2.

Ports:
- `clk_i`  in  1  system clock; single clock domain.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `cio_rx_i`  in  1  raw, asynchronous UART RX line; idle high.
- `rx_en_i`  in  1  receiver enable.
- `baud_div_i`  in  16  oversample tick period minus one; a tick occurs every `baud_div_i`+1 clocks.
- `rdata_o`  out  8  FIFO head byte.
- `rvalid_o`  out  1  FIFO not empty.
- `rready_i`  in  1  consumer accepts `rdata_o` when `rvalid_o`=1.
- `level_o`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.
- `frame_err_o`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun_o`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation

**Synchroniser**
- `SYNC_STAGES` flops. Reset value is 1. The output `rx_s` is the only RX signal used downstream.

**Tick generator**
- 16-bit counter.
- A tick fires when `cnt >= baud_div_i`; the counter then returns to 0. Otherwise the counter increments.
- The `>=` compare makes mid-operation divider changes safe.
- Counter is held at 0 (no ticks) while `rx_en_i`=0.

**FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. All state changes happen only on tick cycles. A 4-bit sample counter `sc` and a 3-bit bit index `bi` support the FSM.
- **IDLE:** on a tick with `rx_s`=0, go to START with `sc`=1.
- **Voting:** in every bit period, `rx_s` is captured at `sc`=7, 8 and 9. The vote is the majority of the three and is evaluated at `sc`=9.
- **START:**
  - At `sc`=9: vote 1 → false start, go to IDLE.
  - At `sc`=15: go to DATA with `sc`=0 and `bi`=0.
- **DATA:**
  - Vote at `sc`=9 is shifted into the shift register LSB-first.
  - At `sc`=15: `bi`++; after `bi`=7, go to STOP with `sc`=0.
- **STOP, decision at `sc`=9:**
  - Vote 1 → push the byte to the FIFO and go to IDLE immediately. Early return gives half a bit of drift tolerance.
  - Vote 1 with the FIFO full and no pop in the same cycle → drop the byte, pulse `overrun_o`, go to IDLE.
  - Vote 0 → drop the byte, pulse `frame_err_o`, go to WAIT_HIGH.
- **WAIT_HIGH:** on a tick with `rx_s`=1, go to IDLE. A break condition therefore produces exactly one `frame_err_o`.
- **`rx_en_i`=0:** FSM is forced to IDLE and `sc`/`bi` are cleared. FIFO contents and `level_o` are retained, and popping still works.

**FIFO**
- Circular buffer with read/write pointers and a level counter.
- Pop when `rvalid_o && rready_i`.
- A push is accepted when level < FIFO_DEPTH, or when a pop occurs in the same cycle. In that case `level_o` is unchanged.
- Pop while empty is ignored.
- `rdata_o` is the head entry. It is 0 when empty after reset; otherwise it is the stale head value.

**Reset values:** `rvalid_o`=0, `rdata_o`=0, `level_o`=0, `frame_err_o`=0, `overrun_o`=0. The FSM is in IDLE, all counters are 0, and FIFO storage is 0.

## Timing

- **Pin to `rx_s`:** `SYNC_STAGES` clocks.
- **Push:** registered on the clock edge ending the STOP `sc`=9 tick cycle. `rvalid_o` and `level_o` update on that edge and are visible the next cycle.
- **Error pulses:** `frame_err_o` and `overrun_o` are registered on the same edge and are high for exactly one clock.
- **Start edge to `rvalid_o`:** about 9.56 bit times + `SYNC_STAGES` clocks, quantised to ticks. With `baud_div_i`=0 (16 clk/bit), this is 153 ± 1 + `SYNC_STAGES` clocks from the falling edge at the pin.
- **Pop:** `rdata_o`, `rvalid_o` and `level_o` update on the edge where `rvalid_o && rready_i`. Back-to-back pops at one per clock are supported.
- **Reset:** asserting `rst_i` clears all state asynchronously, including mid-frame. The first tick after release counts from `cnt`=0.

## Test plan

1. **Basic receive.** `baud_div_i`=0, `rready_i`=1; send 0xA5 8N1 → exactly one `rvalid_o` cycle with `rdata_o`=0xA5. No error pulses. `level_o` returns to 0.
2. **Glitch rejection.** Drive RX low for 4 ticks, then high → no push, FSM back in IDLE. Send 0x3C → 0x3C received.
3. **Majority vote.** In data bit 2 of 0x00, force RX high for only the `sc`=8 sample → 0x00 received. Force it high for `sc`=7..9 → 0x04 received.
4. **Framing error and break.** Send 0x5A with stop bit = 0, then hold RX low for 20 bit times → one `frame_err_o` pulse, no push. Release RX, send 0x55 → 0x55 received.
5. **Overrun.** `FIFO_DEPTH`=4, `rready_i`=0; send 0x01..0x05 → `level_o`=4 and one `overrun_o` pulse on the fifth byte. Pops return 0x01, 0x02, 0x03, 0x04, then `rvalid_o`=0. Also push while full with a simultaneous pop → no overrun, level stays 4.
6. **Reset and divider.** `baud_div_i`=9; assert `rst_i` during data bit 3 → all outputs 0 immediately. Release, send 0x81 → 0x81 received with no error.

Source files
------------

// File: rtl/soc_uart_rx.sv
// rtl/soc_uart_rx.sv - 16x oversampled 8N1 UART receiver with majority vote and receive FIFO
module soc_uart_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cio_rx_i,
  input  logic                          rx_en_i,
  input  logic [15:0]                   baud_div_i,
  output logic [7:0]                    rdata_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          frame_err_o,
  output logic                          overrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [15:0]            cnt_q;
  logic                   tick;
  state_t                 state_q;
  logic [3:0]             sc_q;
  logic [2:0]             bi_q;
  logic [7:0]             shreg_q;
  logic                   v7_q;
  logic                   v8_q;
  logic                   vote;
  logic                   stop_eval;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wptr_q;
  logic [AW-1:0]          rptr_q;
  logic [AW:0]            level_q;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cio_rx_i};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // The >= compare lets a shrinking divider take effect without a counter wrap
  assign tick = rx_en_i && (cnt_q >= baud_div_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 16'd0;
    end else if (!rx_en_i || tick) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign vote = (v7_q & v8_q) | (v7_q & rx_s) | (v8_q & rx_s);

  assign stop_eval = tick && (state_q == STOP) && (sc_q == 4'd9);
  assign full      = (level_q == DEPTH_L);
  assign pop       = rvalid_o && rready_i;
  assign push      = stop_eval && vote && (!full || pop);
  assign drop      = stop_eval && vote && full && !pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sc_q        <= 4'd0;
      bi_q        <= 3'd0;
      shreg_q     <= 8'd0;
      v7_q        <= 1'b0;
      v8_q        <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (!rx_en_i) begin
        state_q <= IDLE;
        sc_q    <= 4'd0;
        bi_q    <= 3'd0;
      end else if (tick) begin
        if (sc_q == 4'd7) v7_q <= rx_s;
        if (sc_q == 4'd8) v8_q <= rx_s;
        unique case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q <= START;
              sc_q    <= 4'd1;
            end
          end
          START: begin
            if ((sc_q == 4'd9) && vote) begin
              state_q <= IDLE;
              sc_q    <= 4'd0;
            end else if (sc_q == 4'd15) begin
              state_q <= DATA;
              sc_q    <= 4'd0;
              bi_q    <= 3'd0;
            end else begin
              sc_q <= sc_q + 4'd1;
            end
          end
          DATA: begin
            sc_q <= sc_q + 4'd1;
            if (sc_q == 4'd9) shreg_q <= {vote, shreg_q[7:1]};
            if (sc_q == 4'd15) begin
              if (bi_q == 3'd7) state_q <= STOP;
              else              bi_q    <= bi_q + 3'd1;
            end
          end
          STOP: begin
            // Leave at mid stop bit so the next start edge is caught despite baud drift
            if (sc_q == 4'd9) begin
              state_q     <= vote ? IDLE : WAIT_HIGH;
              sc_q        <= 4'd0;
              frame_err_o <= !vote;
              overrun_o   <= drop;
            end else begin
              sc_q <= sc_q + 4'd1;
            end
          end
          WAIT_HIGH: begin
            if (rx_s) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= shreg_q;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + (AW+1)'(1);
      else if (pop && !push) level_q <= level_q - (AW+1)'(1);
    end
  end

  assign rdata_o  = mem_q[rptr_q];
  assign rvalid_o = (level_q != '0);
  assign level_o  = level_q;

endmodule

// File: tb/tb_soc_uart_rx.sv
// tb/tb_soc_uart_rx.sv - directed bench for soc_uart_rx
module tb_soc_uart_rx;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cio_rx_i;
  logic       rx_en_i;
  logic [15:0] baud_div_i;
  logic [7:0] rdata_o;
  logic       rvalid_o;
  logic       rready_i;
  logic [2:0] level_o;
  logic       frame_err_o;
  logic       overrun_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int last_pop_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] rxq [$];
  int n0, fe0, ov0, lat;

  soc_uart_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cio_rx_i(cio_rx_i), .rx_en_i(rx_en_i),
    .baud_div_i(baud_div_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .rready_i(rready_i), .level_o(level_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rvalid_o && rready_i) begin
        rxq.push_back(rdata_o);
        last_pop_cyc = cyc;
      end
      if (frame_err_o) fe_cnt++;
      if (overrun_o) ov_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      cio_rx_i = 1'b1;
    end
  endtask

  // Pin value per clock: frame bit, optionally forced high in [glo,ghi]; optional one-clock pop at pop_i
  task automatic drive_frame(input logic [7:0] data, input logic stop, input int bit_clks,
                             input int glo, input int ghi, input int pop_i, input int n_clks);
    logic [9:0] fr;
    fr = {stop, data, 1'b0};
    for (int i = 0; i < n_clks; i++) begin
      @(posedge clk_i); #1;
      if (i == 0) t0 = cyc;
      cio_rx_i = (i >= glo && i <= ghi) ? 1'b1 : fr[4'(i / bit_clks)];
      if (pop_i >= 0) begin
        if (i == pop_i) rready_i = 1'b1;
        else if (i == pop_i + 1) rready_i = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] data, input int bit_clks);
    drive_frame(data, 1'b1, bit_clks, -1, -2, -1, 10 * bit_clks);
  endtask

  initial begin
    rst_i = 1'b1; cio_rx_i = 1'b1; rx_en_i = 1'b1; baud_div_i = 16'd0; rready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_rvalid", rvalid_o, 0);
    chk("reset_rdata", rdata_o, 0);
    chk("reset_level", level_o, 0);
    chk("reset_frame_err", frame_err_o, 0);
    chk("reset_overrun", overrun_o, 0);
    @(posedge clk_i); #1; rst_i = 1'b0;
    idle(20);

    // basic receive
    n0 = rxq.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send(8'hA5, 16); idle(32); @(negedge clk_i);
    lat = last_pop_cyc - t0;
    chk("basic_count", rxq.size(), n0 + 1);
    chk("basic_data", rxq[n0], 8'hA5);
    chk("basic_latency_in_range", (lat >= 154 && lat <= 156), 1);
    chk("basic_no_frame_err", fe_cnt - fe0, 0);
    chk("basic_no_overrun", ov_cnt - ov0, 0);
    chk("basic_level", level_o, 0);

    // glitch rejection
    n0 = rxq.size(); fe0 = fe_cnt;
    for (int i = 0; i < 4; i++) begin @(posedge clk_i); #1; cio_rx_i = 1'b0; end
    idle(64); @(negedge clk_i);
    chk("glitch_no_push", rxq.size(), n0);
    chk("glitch_no_frame_err", fe_cnt - fe0, 0);
    send(8'h3C, 16); idle(32); @(negedge clk_i);
    chk("glitch_then_count", rxq.size(), n0 + 1);
    chk("glitch_then_data", rxq[n0], 8'h3C);

    // majority vote in data bit 2
    n0 = rxq.size();
    drive_frame(8'h00, 1'b1, 16, 56, 56, -1, 160); idle(32); @(negedge clk_i);
    chk("vote_single_sample", rxq[n0], 8'h00);
    drive_frame(8'h00, 1'b1, 16, 55, 57, -1, 160); idle(32); @(negedge clk_i);
    chk("vote_three_samples", rxq[n0 + 1], 8'h04);
    chk("vote_count", rxq.size(), n0 + 2);

    // framing error followed by break
    n0 = rxq.size(); fe0 = fe_cnt;
    drive_frame(8'h5A, 1'b0, 16, -1, -2, -1, 160);
    for (int i = 0; i < 320; i++) begin @(posedge clk_i); #1; cio_rx_i = 1'b0; end
    idle(48); @(negedge clk_i);
    chk("break_one_frame_err", fe_cnt - fe0, 1);
    chk("break_no_push", rxq.size(), n0);
    send(8'h55, 16); idle(32); @(negedge clk_i);
    chk("after_break_data", rxq[n0], 8'h55);

    // overrun
    @(posedge clk_i); #1; rready_i = 1'b0;
    ov0 = ov_cnt;
    for (int b = 1; b <= 5; b++) begin send(8'(b), 16); idle(8); end
    @(negedge clk_i);
    chk("overrun_level", level_o, 4);
    chk("overrun_pulse", ov_cnt - ov0, 1);
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk_i);
      chk("overrun_pop_data", rdata_o, 32'(b));
      chk("overrun_pop_valid", rvalid_o, 1);
      @(posedge clk_i); #1; rready_i = 1'b1;
      @(posedge clk_i); #1; rready_i = 1'b0;
    end
    @(negedge clk_i);
    chk("overrun_drained_valid", rvalid_o, 0);
    chk("overrun_drained_level", level_o, 0);

    // push while full with a simultaneous pop
    for (int b = 8'h11; b <= 8'h14; b++) begin send(8'(b), 16); idle(8); end
    @(negedge clk_i);
    chk("full_level", level_o, 4);
    ov0 = ov_cnt; n0 = rxq.size();
    drive_frame(8'h15, 1'b1, 16, -1, -2, 155, 160); idle(16); @(negedge clk_i);
    chk("full_pop_no_overrun", ov_cnt - ov0, 0);
    chk("full_pop_level", level_o, 4);
    chk("full_pop_head", rdata_o, 8'h12);
    @(posedge clk_i); #1; rready_i = 1'b1;
    idle(8); @(negedge clk_i);
    chk("full_drain_level", level_o, 0);
    chk("full_drain_count", rxq.size(), n0 + 5);
    for (int k = 0; k < 5; k++) chk("full_drain_order", rxq[n0 + k], 32'(8'h11 + k));

    // reset mid-frame with a slower divider
    @(posedge clk_i); #1; rready_i = 1'b0; baud_div_i = 16'd9;
    idle(320);
    send(8'h42, 160); idle(320); @(negedge clk_i);
    chk("div9_level", level_o, 1);
    chk("div9_data", rdata_o, 8'h42);
    drive_frame(8'hC3, 1'b1, 160, -1, -2, -1, 160 * 4 + 80);
    @(posedge clk_i); #1; rst_i = 1'b1; #1;
    chk("midreset_rvalid", rvalid_o, 0);
    chk("midreset_rdata", rdata_o, 0);
    chk("midreset_level", level_o, 0);
    chk("midreset_frame_err", frame_err_o, 0);
    chk("midreset_overrun", overrun_o, 0);
    cio_rx_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1; rst_i = 1'b0; rready_i = 1'b1;
    idle(320);
    n0 = rxq.size(); fe0 = fe_cnt;
    send(8'h81, 160); idle(320); @(negedge clk_i);
    chk("after_reset_count", rxq.size(), n0 + 1);
    chk("after_reset_data", rxq[n0], 8'h81);
    chk("after_reset_no_frame_err", fe_cnt - fe0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
